// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB encodings for the three-master fabric: master ids, HTRANS/HBURST codes
// and the fixed-burst length decode used by the arbiter's beat tracking.
package ahb_arbiter_pkg;

  localparam int AHB_TRANS_BITS  = 2;
  localparam int AHB_BURST_BITS  = 3;
  localparam int AHB_MASTER_BITS = 2;

  localparam logic [AHB_MASTER_BITS-1:0] AHB_MASTER_0 = 2'd0;
  localparam logic [AHB_MASTER_BITS-1:0] AHB_MASTER_1 = 2'd1;
  localparam logic [AHB_MASTER_BITS-1:0] AHB_MASTER_2 = 2'd2;
  localparam logic [AHB_MASTER_BITS-1:0] AHB_MASTER_3 = 2'd3;

  typedef enum logic [AHB_TRANS_BITS-1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [AHB_BURST_BITS-1:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  // Beats in a burst; undefined-length INCR counts as 1 so it never blocks arbitration.
  function automatic logic [4:0] ahb_burst_len(input logic [AHB_BURST_BITS-1:0] burst);
    logic [4:0] len;
    len = 5'd1;
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
      default:                      len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_arbiter_burst_tracker.sv
// Counts address phases left in the current fixed-length burst from the muxed
// HTRANS/HBURST, and flags when the bus may be re-arbitrated.
module ahb_burst_tracker
  import ahb_arbiter_pkg::*;
#(
  parameter int BEAT_CNT_BITS = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HREADY,
  input  logic [AHB_TRANS_BITS-1:0] HTRANS,
  input  logic [AHB_BURST_BITS-1:0] HBURST,
  output logic [BEAT_CNT_BITS-1:0]  beats_next,
  output logic                      last_beat
);

  logic [BEAT_CNT_BITS-1:0] beats_left;

  always_comb begin
    beats_next = beats_left;
    if (HREADY) begin
      case (HTRANS)
        HTRANS_IDLE:   beats_next = '0;
        HTRANS_BUSY:   beats_next = beats_left;
        HTRANS_NONSEQ: beats_next = BEAT_CNT_BITS'(ahb_burst_len(HBURST) - 5'd1);
        HTRANS_SEQ:    beats_next = (beats_left != '0) ? beats_left - BEAT_CNT_BITS'(1) : '0;
        default:       beats_next = beats_left;
      endcase
    end
  end

  // <=1 lets the grant move during the second-to-last beat, so the new owner
  // takes HMASTER exactly as the last address phase completes.
  assign last_beat = (beats_next <= BEAT_CNT_BITS'(1));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) beats_left <= '0;
    else          beats_left <= beats_next;
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin arbiter for the three-master AHB fabric: registered grants, HMASTER
// handover on HREADY, burst-aware and HLOCK-aware re-arbitration, parking on master 0.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
#(
  parameter int BEAT_CNT_BITS = 4
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       HBUSREQ_M1,
  input  logic                       HBUSREQ_M2,
  input  logic                       HBUSREQ_M3,
  input  logic                       HLOCK_M1,
  input  logic                       HLOCK_M2,
  input  logic                       HLOCK_M3,
  input  logic [AHB_TRANS_BITS-1:0]  HTRANS,
  input  logic [AHB_BURST_BITS-1:0]  HBURST,
  input  logic                       HREADY,
  output logic                       HGRANT_M1,
  output logic                       HGRANT_M2,
  output logic                       HGRANT_M3,
  output logic [AHB_MASTER_BITS-1:0] HMASTER,
  output logic                       HMASTLOCK
);

  logic [3:0]                 req_v, lock_v;
  logic [AHB_MASTER_BITS-1:0] grant_q, winner;
  logic [BEAT_CNT_BITS-1:0]   beats_next;
  logic                       last_beat, arb_en;

  // Slot 0 is the default master: never requests, never locks.
  assign req_v  = {HBUSREQ_M3, HBUSREQ_M2, HBUSREQ_M1, 1'b0};
  assign lock_v = {HLOCK_M3,   HLOCK_M2,   HLOCK_M1,   1'b0};

  ahb_burst_tracker #(.BEAT_CNT_BITS(BEAT_CNT_BITS)) u_trk (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HREADY     (HREADY),
    .HTRANS     (HTRANS),
    .HBURST     (HBURST),
    .beats_next (beats_next),
    .last_beat  (last_beat)
  );

  // Walk HMASTER+1 .. HMASTER over 1..3 backwards so the earliest requester wins.
  always_comb begin
    logic [AHB_MASTER_BITS-1:0] cand;
    winner = AHB_MASTER_0;
    cand   = AHB_MASTER_0;
    for (int i = 3; i >= 1; i--) begin
      cand = AHB_MASTER_BITS'((int'(HMASTER) + i - 1) % 3 + 1);
      if (req_v[cand]) winner = cand;
    end
  end

  assign arb_en = HREADY && (grant_q == HMASTER) && last_beat && !lock_v[grant_q];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      grant_q   <= AHB_MASTER_0;
      HMASTER   <= AHB_MASTER_0;
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      HMASTER   <= grant_q;
      HMASTLOCK <= lock_v[grant_q];
      if (arb_en) grant_q <= winner;
    end
  end

  assign HGRANT_M1 = (grant_q == AHB_MASTER_1);
  assign HGRANT_M2 = (grant_q == AHB_MASTER_2);
  assign HGRANT_M3 = (grant_q == AHB_MASTER_3);

  a_last_beat: assert property (@(posedge HCLK) disable iff (!HRESETn)
    last_beat == (beats_next <= BEAT_CNT_BITS'(1)));

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, single requester, round-robin order,
// INCR8 handover with and without stalls, HLOCK hold, reset mid-burst.
module tb_ahb_arbiter;
  import ahb_arbiter_pkg::*;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       HBUSREQ_M1, HBUSREQ_M2, HBUSREQ_M3;
  logic       HLOCK_M1, HLOCK_M2, HLOCK_M3;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic       HGRANT_M1, HGRANT_M2, HGRANT_M3;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;
  logic [2:0] gnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;
  assign gnt = {HGRANT_M3, HGRANT_M2, HGRANT_M1};

  ahb_arbiter #(.BEAT_CNT_BITS(4)) u_dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HBUSREQ_M1 (HBUSREQ_M1),
    .HBUSREQ_M2 (HBUSREQ_M2),
    .HBUSREQ_M3 (HBUSREQ_M3),
    .HLOCK_M1   (HLOCK_M1),
    .HLOCK_M2   (HLOCK_M2),
    .HLOCK_M3   (HLOCK_M3),
    .HTRANS     (HTRANS),
    .HBURST     (HBURST),
    .HREADY     (HREADY),
    .HGRANT_M1  (HGRANT_M1),
    .HGRANT_M2  (HGRANT_M2),
    .HGRANT_M3  (HGRANT_M3),
    .HMASTER    (HMASTER),
    .HMASTLOCK  (HMASTLOCK)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    {HBUSREQ_M1, HBUSREQ_M2, HBUSREQ_M3} = '0;
    {HLOCK_M1, HLOCK_M2, HLOCK_M3}       = '0;
    HTRANS = HTRANS_IDLE;
    HBURST = HBURST_SINGLE;
    HREADY = 1'b1;
    tick();
    tick();
    HRESETn = 1'b1;
  endtask

  // Make M1 the owner: grant after one edge, HMASTER after the next.
  task automatic own_m1();
    HBUSREQ_M1 = 1'b1;
    tick();
    tick();
    chk("own_m1_hmaster", HMASTER, 1);
  endtask

  // INCR8 by M1 with M3 waiting; optional 2-cycle stall in front of beat 4.
  task automatic burst8(input bit stall);
    HBUSREQ_M3 = 1'b1;
    HTRANS     = HTRANS_NONSEQ;
    HBURST     = HBURST_INCR8;
    tick();
    chk("b8_beat1_gnt", gnt, 3'b001);
    HTRANS = HTRANS_SEQ;
    for (int b = 2; b <= 8; b++) begin
      if (stall && b == 4) begin
        HREADY = 1'b0;
        tick();
        tick();
        chk("b8_stall_gnt", gnt, 3'b001);
        chk("b8_stall_beats", u_dut.u_trk.beats_left, 5);
        HREADY = 1'b1;
      end
      tick();
      chk($sformatf("b8_beat%0d_gnt", b), gnt, (b >= 7) ? 3'b100 : 3'b001);
      if (b == 7) chk("b8_beat7_hmaster", HMASTER, 1);
    end
    chk("b8_beat8_hmaster", HMASTER, 3);
    HTRANS = HTRANS_IDLE;
  endtask

  initial begin
    int seq[4];

    // Reset, no requests
    do_reset();
    repeat (5) tick();
    chk("rst_hmaster", HMASTER, 0);
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_mastlock", HMASTLOCK, 0);
    chk("rst_beats", u_dut.u_trk.beats_left, 0);

    // Single request from M2
    HBUSREQ_M2 = 1'b1;
    tick();
    chk("single_gnt", gnt, 3'b010);
    chk("single_hmaster_lag", HMASTER, 0);
    tick();
    chk("single_hmaster", HMASTER, 2);
    HTRANS = HTRANS_NONSEQ;
    repeat (3) tick();
    chk("single_hold", gnt, 3'b010);

    // Dropping request under stall keeps the grant; next ready edge parks on 0
    HBUSREQ_M2 = 1'b0;
    HTRANS     = HTRANS_IDLE;
    HREADY     = 1'b0;
    tick();
    tick();
    chk("stall_keep_gnt", gnt, 3'b010);
    chk("stall_keep_hmaster", HMASTER, 2);
    HREADY = 1'b1;
    tick();
    chk("park_gnt", gnt, 3'b000);
    tick();
    chk("park_hmaster", HMASTER, 0);

    // All three requesting from owner 1: 2, 3, 1, 2
    do_reset();
    own_m1();
    {HBUSREQ_M1, HBUSREQ_M2, HBUSREQ_M3} = 3'b111;
    HTRANS = HTRANS_NONSEQ;
    HBURST = HBURST_SINGLE;
    seq = '{2, 3, 1, 2};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr%0d_gnt", i), gnt, 3'b001 << (seq[i] - 1));
      tick();
      chk($sformatf("rr%0d_hmaster", i), HMASTER, seq[i]);
    end

    // INCR8 handover, then same with a stall
    do_reset();
    own_m1();
    burst8(1'b0);
    do_reset();
    own_m1();
    burst8(1'b1);

    // Lock hold by M2
    do_reset();
    HBUSREQ_M2 = 1'b1;
    HLOCK_M2   = 1'b1;
    HTRANS     = HTRANS_NONSEQ;
    HBURST     = HBURST_SINGLE;
    tick();
    chk("lock_gnt", gnt, 3'b010);
    chk("lock_mastlock_lag", HMASTLOCK, 0);
    HBUSREQ_M1 = 1'b1;
    HBUSREQ_M3 = 1'b1;
    tick();
    chk("lock_hmaster", HMASTER, 2);
    chk("lock_mastlock", HMASTLOCK, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("lock_hold%0d_gnt", i), gnt, 3'b010);
      chk($sformatf("lock_hold%0d_ml", i), HMASTLOCK, 1);
    end
    HLOCK_M2 = 1'b0;
    tick();
    chk("unlock_gnt", gnt, 3'b100);
    chk("unlock_mastlock", HMASTLOCK, 0);

    // Reset in beat 3 of WRAP16
    do_reset();
    own_m1();
    HBUSREQ_M3 = 1'b1;
    HTRANS     = HTRANS_NONSEQ;
    HBURST     = HBURST_WRAP16;
    tick();
    HTRANS = HTRANS_SEQ;
    tick();
    chk("w16_beats", u_dut.u_trk.beats_left, 14);
    chk("w16_gnt", gnt, 3'b001);
    HRESETn = 1'b0;
    tick();
    chk("midrst_hmaster", HMASTER, 0);
    chk("midrst_gnt", gnt, 3'b000);
    chk("midrst_mastlock", HMASTLOCK, 0);
    chk("midrst_beats", u_dut.u_trk.beats_left, 0);
    HRESETn = 1'b1;
    HTRANS  = HTRANS_IDLE;
    tick();
    chk("postrst_gnt", gnt, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
